div_64_23_recon: RTL and testbench
==================================

Name: div_64_23_recon

Overview:
- Inverse of the divide-by-23 datapath: takes a quotient Q and remainder R and rebuilds the dividend X = Q*23 + R.
- Used as the write-back/self-check end of the constant-division pipeline, where a result produced by the divider is turned back into a 64-bit operand.
- Bit-serial shift-add over the divisor constant bits, with a valid/ready handshake on both sides.
- Flags remainders that are out of range and results that do not fit in 64 bits.

Parameters:
- Q_W, 60, quotient width.
- R_W, 5, remainder width; DIVISOR <= 2^R_W is required.
- X_W, 64, reconstructed dividend width.
- DIVISOR, 23, constant multiplier (binary 10111).
- DIV_W, 5, number of DIVISOR bits processed (bit-length of DIVISOR).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  Q_in/R_in valid.
- in_ready  out  1  block can accept an operand pair.
- Q_in  in  Q_W  quotient.
- R_in  in  R_W  remainder.
- out_valid  out  1  X_out and flags valid.
- out_ready  in  1  downstream accepts the result.
- X_out  out  X_W  reconstructed dividend, low X_W bits of Q*DIVISOR+R.
- ovf  out  1  full result >= 2^X_W.
- rem_err  out  1  R_in >= DIVISOR for this result.

Behaviour:
- Reset is asynchronous and active-low (rst_n low):
  - state IDLE; in_ready=0, out_valid=0, X_out=0, ovf=0, rem_err=0; internal acc, q_reg and cnt cleared.
  - in_ready rises on the first rising clk edge after rst_n deasserts.
- States are IDLE, CALC and DONE.
- IDLE, in_ready=1:
  - On an edge with in_valid&&in_ready: q_reg<=Q_in; acc (X_W+1 bits) <= zero-extended R_in; rem_err<=(R_in>=DIVISOR); cnt<=0; in_ready<=0; go to CALC.
- CALC:
  - Each edge: if DIVISOR[cnt]==1 then acc <= acc + (q_reg << cnt), computed at X_W+1 bits; cnt<=cnt+1.
  - At the edge that processes cnt==DIV_W-1: go to DONE and set out_valid<=1.
- acc has X_W+1 bits. Q_W+DIV_W = 65 <= X_W+1, so no intermediate truncation occurs.
- DONE:
  - X_out=acc[X_W-1:0]; ovf=acc[X_W].
  - Outputs are held stable while out_valid=1 && out_ready=0.
  - On an edge with out_valid&&out_ready: out_valid<=0, in_ready<=1, go to IDLE. X_out and the flags keep their last values.
- Latency: out_valid rises DIV_W edges after the accept edge (5 for the defaults).
- Throughput: at most one operand per DIV_W+2 cycles. No input is accepted in the same cycle a result is consumed.
- in_valid/Q_in/R_in are ignored outside IDLE.
- out_ready is ignored while out_valid=0.
- Remainder errors:
  - When rem_err=1 the result is still computed arithmetically as Q*23+R.
  - rem_err is informational only.
- Reset asserted during CALC or DONE aborts the operation immediately. No result is emitted, and outputs return to their reset values.
- Q_in=0: the result equals R_in after the full latency. There is no early-out.

Optional Feature:
- Macro: DIV_RECON_RADIX4_EN.
- When defined: CALC processes two DIVISOR bits per edge (cnt steps by 2), adding the terms for bits cnt and cnt+1 in one edge.
  - Latency becomes ceil(DIV_W/2) edges (3 for the defaults).
  - Throughput is one per ceil(DIV_W/2)+2 cycles.
  - An odd top bit is processed alone.
- When undefined: one bit per edge as specified above.
- Results and flags are identical in both builds.

Test Plan:
- Reset, then Q_in=0, R_in=0, in_valid pulse -> out_valid exactly 5 edges after accept; X_out=0, ovf=0, rem_err=0.
- Q_in=123456789, R_in=5 -> X_out=2839506152, ovf=0, rem_err=0. Repeat with Q_in=1, R_in=22 -> X_out=45.
- Q_in=2^60-1, R_in=22 -> X_out=0x6FFFFFFFFFFFFFFF, ovf=1.
- Q_in=10, R_in=23 -> X_out=253, rem_err=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 with new data -> X_out, flags and out_valid stay stable and in_ready stays 0. Release out_ready -> in_ready=1 on the next edge, then the new operand is accepted.
- Assert rst_n=0 for 1 cycle during the third CALC cycle -> all outputs read 0 immediately, no out_valid appears, and in_ready=1 one edge after release. Rerun each case with DIV_RECON_RADIX4_EN defined and check a latency of 3.

Source files
------------

// File: rtl/div_64_23_recon.sv
// div_64_23_recon
//   Rebuilds a dividend from a divide-by-DIVISOR result: X = Q*DIVISOR + R.
//   It is a bit-serial shift-add over the bits of the constant DIVISOR. The
//   accumulator starts at R, and one shifted copy of Q is added for each set
//   divisor bit. Both sides use a valid/ready handshake.
//
//   Optional build macro: DIV_RECON_RADIX4_EN
//     When defined, two divisor bits are retired per clock, so the latency is
//     ceil(DIV_W/2) instead of DIV_W. The results and flags are identical in
//     both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   Q_in/R_in valid
//   in_ready   out  block can accept an operand pair (only in IDLE)
//   Q_in       in   [Q_W]  quotient
//   R_in       in   [R_W]  remainder
//   out_valid  out  X_out/ovf/rem_err valid
//   out_ready  in   downstream accepts the result
//   X_out      out  [X_W]  low X_W bits of Q*DIVISOR+R
//   ovf        out  full result does not fit in X_W bits
//   rem_err    out  R_in >= DIVISOR for this operand
module div_64_23_recon #(
  parameter int Q_W     = 60,
  parameter int R_W     = 5,
  parameter int X_W     = 64,
  parameter int DIVISOR = 23,
  parameter int DIV_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] Q_in,
  input  logic [R_W-1:0] R_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] X_out,
  output logic           ovf,
  output logic           rem_err
);

  localparam int ACC_W = X_W + 1;
  localparam int CNT_W = $clog2(DIV_W + 2);
`ifdef DIV_RECON_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [DIV_W-1:0] DIV_BITS = DIV_W'(DIVISOR);
  localparam logic [R_W:0]     DIV_R    = (R_W + 1)'(DIVISOR);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] NBITS_C  = CNT_W'(DIV_W);
  // The last CALC edge is the one whose step reaches past the top divisor bit.
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(DIV_W - STEP);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [Q_W-1:0]   q_reg_q, q_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic             ovf_q, ovf_d;
  logic             rem_err_q, rem_err_d;
  logic [ACC_W-1:0] acc_next;

  // Partial product for divisor bit k. This is zero when k lies above the top
  // bit, which happens for the unpaired top bit in the two-bits-per-edge build.
  function automatic logic [ACC_W-1:0] term(input logic [Q_W-1:0]   q,
                                            input logic [CNT_W-1:0] k);
    logic [ACC_W-1:0] t;
    t = '0;
    if (k < NBITS_C) begin
      if (DIV_BITS[k]) t = ACC_W'(q) << k;
    end
    return t;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      q_reg_q     <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      rem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      q_reg_q     <= q_reg_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ovf_q       <= ovf_d;
      rem_err_q   <= rem_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    q_reg_d     = q_reg_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    ovf_d       = ovf_q;
    rem_err_d   = rem_err_q;
    acc_next    = acc_q + term(q_reg_q, cnt_q);
`ifdef DIV_RECON_RADIX4_EN
    acc_next    = acc_next + term(q_reg_q, cnt_q + CNT_W'(1));
`endif
    unique case (state_q)
      IDLE: begin
        // in_ready is low on entry from reset. It comes up one edge later.
        if (!in_ready_q) begin
          in_ready_d = 1'b1;
        end else if (in_valid) begin
          q_reg_d    = Q_in;
          acc_d      = ACC_W'(R_in);
          rem_err_d  = ({1'b0, R_in} >= DIV_R);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + STEP_C;
        if (cnt_q >= DONE_CNT) begin
          // Capture the result separately so it stays visible after hand-off.
          x_d         = acc_next[X_W-1:0];
          ovf_d       = acc_next[X_W];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    X_out     = x_q;
    ovf       = ovf_q;
    rem_err   = rem_err_q;
  end

endmodule

// File: tb/tb_div_64_23_recon.sv
module tb_div_64_23_recon;
  localparam int Q_W = 60;
  localparam int R_W = 5;
  localparam int X_W = 64;
`ifdef DIV_RECON_RADIX4_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, out_valid, out_ready, ovf, rem_err;
  logic [Q_W-1:0] q_in;
  logic [R_W-1:0] r_in;
  logic [X_W-1:0] x_out;
  int             n_checks = 0;
  int             n_errors = 0;

  always #5 clk = ~clk;

  div_64_23_recon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q_in      (q_in),
    .R_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X_out     (x_out),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic on the definition X = Q*23 + R.
  function automatic logic [64:0] ref_full(input logic [Q_W-1:0] q, input logic [R_W-1:0] r);
    return 65'(q) * 65'd23 + 65'(r);
  endfunction

  task automatic send(input logic [Q_W-1:0] q, input logic [R_W-1:0] r, input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    q_in = q; r_in = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic wait_result(input logic [Q_W-1:0] q, input logic [R_W-1:0] r,
                             input string tag, output logic [63:0] xo);
    int n = 0;
    logic [64:0] full;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    full = ref_full(q, r);
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    chk({tag, "_x"}, x_out, full[63:0]);
    chk({tag, "_flags"}, {62'd0, ovf, rem_err}, {62'd0, full[64], (r >= 5'd23)});
    xo = x_out;
  endtask

  task automatic consume(input string tag, input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op(input logic [Q_W-1:0] q, input logic [R_W-1:0] r, input string tag,
                    output logic [63:0] xo);
    send(q, r, tag);
    wait_result(q, r, tag, xo);
    consume(tag, 0);
  endtask

  initial begin
    logic [63:0]    x, xa;
    logic [Q_W-1:0] q, qb;
    logic [R_W-1:0] r, rb;
    logic [64:0]    fa;
    logic           seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q_in = '0; r_in = '0;
    #12;
    chk("rst_outs", {in_ready, out_valid, ovf, rem_err}, 64'd0);
    chk("rst_x", x_out, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_rdy_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_rdy_high", 64'(in_ready), 64'd1);

    // Directed test-plan points
    op(60'd0, 5'd0, "zero", x);
    chk("tp_zero", x, 64'd0);
    op(60'd123456789, 5'd5, "q123", x);
    chk("tp_q123", x, 64'd2839506152);
    op(60'd1, 5'd22, "q1r22", x);
    chk("tp_q1r22", x, 64'd45);
    op({60{1'b1}}, 5'd22, "qmax", x);
    chk("tp_qmax", x, 64'h6FFF_FFFF_FFFF_FFFF);
    chk("tp_qmax_ovf", 64'(ovf), 64'd1);
    op(60'd10, 5'd23, "rerr", x);
    chk("tp_rerr", x, 64'd253);
    chk("tp_rerr_flags", {ovf, rem_err}, 64'd1);

    // Backpressure: the result must hold while new data is waiting
    q = {$urandom(), $urandom()};
    r = 5'($urandom_range(0, 31));
    send(q, r, "bpA");
    wait_result(q, r, "bpA", xa);
    fa = ref_full(q, r);
    qb = {$urandom(), $urandom()};
    rb = 5'($urandom_range(0, 31));
    q_in = qb; r_in = rb; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_x", x_out, xa);
      chk("bp_hold_ctl", {out_valid, in_ready, ovf, rem_err},
          {1'b1, 1'b0, fa[64], (r >= 5'd23)});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {in_ready, out_valid}, 64'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_acceptB", 64'(in_ready), 64'd0);
    wait_result(qb, rb, "bpB", x);
    consume("bpB", 0);

    // Reset in the third CALC cycle aborts the operation
    send(60'd987654321, 5'd7, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {in_ready, out_valid, ovf, rem_err}, 64'd0);
    chk("abort_x", x_out, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_rdy_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("abort_rdy_high", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    // Randomized operands with random downstream stalls
    for (int i = 0; i < 40; i++) begin
      q = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) q = q >> $urandom_range(4, 56);
      r = 5'($urandom_range(0, 31));
      send(q, r, "rnd");
      wait_result(q, r, "rnd", x);
      consume("rnd", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
